cursor_ctrl: RTL and testbench

- Consumer stage directly downstream of the PS/2 keyboard receiver.
- Takes the receiver's 8-bit scan-code byte and one-cycle ready strobe. Turns arrow-key and Enter presses into a bounded cursor position (x, y) plus event pulses for the display/drawing logic.
- The receiver strobes ready once for a key's make code and once more for the code byte that follows a break (F0) prefix. The E0 prefix is already stripped.
- This block therefore pairs strobes into press/release with a per-key held tracker. Movement happens on press only.

---
 rtl/ps2_codes.sv | 25 ++
 rtl/cursor_ctrl_if.sv | 28 ++
 rtl/cursor_axis.sv | 67 ++++++
 rtl/cursor_ctrl.sv | 105 ++++++++++
 tb/tb_cursor_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ps2_codes.sv
// ps2_codes: scan-code constants shared by the PS/2 receiver and its consumers.
//   SC_UP/DOWN/LEFT/RIGHT/ENTER : set-2 codes of the keys the cursor block acts on
//   SC_NONE                     : "no key held" marker
//   SC_EXT / SC_BREAK           : receiver prefix bytes; the receiver consumes these
//                                 and never forwards them downstream
package ps2_codes;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_NONE  = 8'h00;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // True for the five codes this block reacts to; everything else is ignored.
  function automatic logic is_recognised(input logic [7:0] code);
    return (code == SC_UP)   || (code == SC_DOWN)  ||
           (code == SC_LEFT) || (code == SC_RIGHT) ||
           (code == SC_ENTER);
  endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: keyboard-byte input and cursor/event outputs of cursor_ctrl.
//   code_in/code_valid : scan-code byte and one-cycle ready strobe from the receiver
//   cursor_x/cursor_y  : current cursor position
//   moved/select       : one-cycle event pulses
//   held_code          : code of the key currently held, 8'h00 when none
// Modports: master = receiver/display side, slave = cursor_ctrl.
interface cursor_ctrl_if #(
  parameter int X_W = 7,
  parameter int Y_W = 6
);
  logic [7:0]     code_in;
  logic           code_valid;
  logic [X_W-1:0] cursor_x;
  logic [Y_W-1:0] cursor_y;
  logic           moved;
  logic           select;
  logic [7:0]     held_code;

  modport master (
    output code_in, code_valid,
    input  cursor_x, cursor_y, moved, select, held_code
  );

  modport slave (
    input  code_in, code_valid,
    output cursor_x, cursor_y, moved, select, held_code
  );
endinterface

// File: rtl/cursor_axis.sv
// cursor_axis: one bounded cursor coordinate (0..MAX) with saturate or wrap edges.
//   clk, rst_n : clock and asynchronous active-low reset (already synchronised)
//   inc, dec   : one-step move requests (simultaneous requests cancel)
//   pos        : registered position, resets to MAX/2
//   changed    : registered pulse, high the cycle after pos actually changed
module cursor_axis #(
  parameter int MAX  = 79,
  parameter int W    = 7,
  parameter bit WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] pos,
  output logic         changed
);

  localparam logic [W-1:0] MAX_V   = W'(MAX);
  localparam logic [W-1:0] RESET_V = W'(MAX / 2);

  logic [W-1:0] r_pos;
  logic         r_changed;
  logic [W-1:0] w_pos_next;
  logic         w_changed_next;

  // Edge comparison happens before the step so the value never leaves 0..MAX.
  always_comb begin
    w_pos_next     = r_pos;
    w_changed_next = 1'b0;
    if (inc && !dec) begin
      if (r_pos == MAX_V) begin
        if (WRAP) begin
          w_pos_next     = '0;
          w_changed_next = 1'b1;
        end
      end else begin
        w_pos_next     = r_pos + 1'b1;
        w_changed_next = 1'b1;
      end
    end else if (dec && !inc) begin
      if (r_pos == '0) begin
        if (WRAP) begin
          w_pos_next     = MAX_V;
          w_changed_next = 1'b1;
        end
      end else begin
        w_pos_next     = r_pos - 1'b1;
        w_changed_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos     <= RESET_V;
      r_changed <= 1'b0;
    end else begin
      r_pos     <= w_pos_next;
      r_changed <= w_changed_next;
    end
  end

  assign pos     = r_pos;
  assign changed = r_changed;

endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: turns PS/2 arrow/Enter scan codes into a bounded cursor and events.
//   clk : system clock (same as the keyboard receiver)
//   rst : asynchronous active-low reset; release is synchronised internally
//   io  : cursor_ctrl_if.slave
//         in : code_in, code_valid
//         out: cursor_x, cursor_y, moved, select, held_code
// The receiver strobes once for a make code and once for the code after a break
// prefix, so strobes of the same code alternate press/release via held_code.
module cursor_ctrl
  import ps2_codes::*;
#(
  parameter int X_MAX = 79,
  parameter int Y_MAX = 59,
  parameter int X_W   = 7,
  parameter int Y_W   = 6,
  parameter bit WRAP  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  cursor_ctrl_if.slave io
);

  // Assertion propagates immediately; release waits two clock edges.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic [7:0] r_held_code;
  logic       r_select;

  logic w_strobe;
  logic w_press;
  logic w_up, w_down, w_left, w_right, w_enter;

  // A recognised strobe that differs from the held key is a press (this also
  // covers replacing a different held key); a repeat of the held key is a release.
  assign w_strobe = io.code_valid && is_recognised(io.code_in);
  assign w_press  = w_strobe && (io.code_in != r_held_code);

  assign w_up    = w_press && (io.code_in == SC_UP);
  assign w_down  = w_press && (io.code_in == SC_DOWN);
  assign w_left  = w_press && (io.code_in == SC_LEFT);
  assign w_right = w_press && (io.code_in == SC_RIGHT);
  assign w_enter = w_press && (io.code_in == SC_ENTER);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_held_code <= SC_NONE;
      r_select    <= 1'b0;
    end else begin
      r_select <= w_enter;
      if (w_strobe) begin
        r_held_code <= w_press ? io.code_in : SC_NONE;
      end
    end
  end

  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  logic           w_x_changed;
  logic           w_y_changed;

  cursor_axis #(
    .MAX  (X_MAX),
    .W    (X_W),
    .WRAP (WRAP)
  ) u_axis_x (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .inc     (w_right),
    .dec     (w_left),
    .pos     (w_x),
    .changed (w_x_changed)
  );

  // Screen rows grow downwards: down increments y.
  cursor_axis #(
    .MAX  (Y_MAX),
    .W    (Y_W),
    .WRAP (WRAP)
  ) u_axis_y (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .inc     (w_down),
    .dec     (w_up),
    .pos     (w_y),
    .changed (w_y_changed)
  );

  assign io.cursor_x  = w_x;
  assign io.cursor_y  = w_y;
  assign io.moved     = w_x_changed | w_y_changed;
  assign io.select    = r_select;
  assign io.held_code = r_held_code;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: a saturating (WRAP=0) and a wrapping (WRAP=1)
// instance receive identical stimulus. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_cursor_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cursor_ctrl_if #(.X_W(7), .Y_W(6)) bus0 ();
  cursor_ctrl_if #(.X_W(7), .Y_W(6)) bus1 ();

  cursor_ctrl #(.X_MAX(79), .Y_MAX(59), .X_W(7), .Y_W(6), .WRAP(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .io  (bus0.slave)
  );

  cursor_ctrl #(.X_MAX(79), .Y_MAX(59), .X_W(7), .Y_W(6), .WRAP(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .io  (bus1.slave)
  );

  task automatic drive(input logic [7:0] code, input logic valid);
    bus0.code_in = code; bus0.code_valid = valid;
    bus1.code_in = code; bus1.code_valid = valid;
  endtask

  // Called and returns on a falling edge; the strobe's result is visible on return.
  task automatic strobe(input logic [7:0] code);
    drive(code, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    drive(8'h00, 1'b0);
    rst = 1'b0;
    idle(3);
    n_cmp++; if (bus0.cursor_x !== 7'd39) begin n_err++; $display("FAIL rst_x got %0d want 39", bus0.cursor_x); end
    n_cmp++; if (bus0.cursor_y !== 6'd29) begin n_err++; $display("FAIL rst_y got %0d want 29", bus0.cursor_y); end
    rst = 1'b1;
    idle(10);
    n_cmp++; if (bus0.cursor_x !== 7'd39) begin n_err++; $display("FAIL idle_x got %0d want 39", bus0.cursor_x); end
    n_cmp++; if (bus0.cursor_y !== 6'd29) begin n_err++; $display("FAIL idle_y got %0d want 29", bus0.cursor_y); end
    n_cmp++; if (bus0.moved !== 1'b0) begin n_err++; $display("FAIL idle_moved got %b want 0", bus0.moved); end
    n_cmp++; if (bus0.select !== 1'b0) begin n_err++; $display("FAIL idle_select got %b want 0", bus0.select); end
    n_cmp++; if (bus0.held_code !== 8'h00) begin n_err++; $display("FAIL idle_held got %h want 00", bus0.held_code); end
    $display("test_reset: x=%0d y=%0d held=%h", bus0.cursor_x, bus0.cursor_y, bus0.held_code);
  endtask

  task automatic test_tap_right;
    strobe(8'h74);
    n_cmp++; if (bus0.cursor_x !== 7'd40) begin n_err++; $display("FAIL tap_x got %0d want 40", bus0.cursor_x); end
    n_cmp++; if (bus0.moved !== 1'b1) begin n_err++; $display("FAIL tap_moved got %b want 1", bus0.moved); end
    n_cmp++; if (bus0.held_code !== 8'h74) begin n_err++; $display("FAIL tap_held got %h want 74", bus0.held_code); end
    idle(1);
    n_cmp++; if (bus0.moved !== 1'b0) begin n_err++; $display("FAIL tap_moved_drop got %b want 0", bus0.moved); end
    strobe(8'h74);
    n_cmp++; if (bus0.cursor_x !== 7'd40) begin n_err++; $display("FAIL rel_x got %0d want 40", bus0.cursor_x); end
    n_cmp++; if (bus0.moved !== 1'b0) begin n_err++; $display("FAIL rel_moved got %b want 0", bus0.moved); end
    n_cmp++; if (bus0.held_code !== 8'h00) begin n_err++; $display("FAIL rel_held got %h want 00", bus0.held_code); end
    idle(1);
    n_cmp++; if (bus0.cursor_x !== 7'd40) begin n_err++; $display("FAIL rel_x_stay got %0d want 40", bus0.cursor_x); end
    $display("test_tap_right: x=%0d held=%h", bus0.cursor_x, bus0.held_code);
  endtask

  task automatic test_left_edge;
    // Walk from x=40 down to 0 with press/release pairs.
    for (int i = 0; i < 40; i++) begin
      strobe(8'h6B);
      n_cmp++; if (bus0.cursor_x !== 7'(39 - i) || bus0.moved !== 1'b1) begin
        n_err++; $display("FAIL walk_left step %0d got x=%0d moved=%b want x=%0d moved=1", i, bus0.cursor_x, bus0.moved, 39 - i);
      end
      strobe(8'h6B);
      n_cmp++; if (bus0.moved !== 1'b0 || bus0.held_code !== 8'h00) begin
        n_err++; $display("FAIL walk_release step %0d got moved=%b held=%h want 0/00", i, bus0.moved, bus0.held_code);
      end
    end
    n_cmp++; if (bus1.cursor_x !== 7'd0) begin n_err++; $display("FAIL wrap_start got %0d want 0", bus1.cursor_x); end
    strobe(8'h6B);
    n_cmp++; if (bus0.cursor_x !== 7'd0) begin n_err++; $display("FAIL sat_x got %0d want 0", bus0.cursor_x); end
    n_cmp++; if (bus0.moved !== 1'b0) begin n_err++; $display("FAIL sat_moved got %b want 0", bus0.moved); end
    n_cmp++; if (bus0.held_code !== 8'h6B) begin n_err++; $display("FAIL sat_held got %h want 6b", bus0.held_code); end
    n_cmp++; if (bus1.cursor_x !== 7'd79) begin n_err++; $display("FAIL wrap_x got %0d want 79", bus1.cursor_x); end
    n_cmp++; if (bus1.moved !== 1'b1) begin n_err++; $display("FAIL wrap_moved got %b want 1", bus1.moved); end
    strobe(8'h6B);
    n_cmp++; if (bus0.cursor_x !== 7'd0 || bus0.moved !== 1'b0) begin n_err++; $display("FAIL sat_rel got x=%0d moved=%b want 0/0", bus0.cursor_x, bus0.moved); end
    n_cmp++; if (bus1.cursor_x !== 7'd79 || bus1.moved !== 1'b0) begin n_err++; $display("FAIL wrap_rel got x=%0d moved=%b want 79/0", bus1.cursor_x, bus1.moved); end
    $display("test_left_edge: sat_x=%0d wrap_x=%0d", bus0.cursor_x, bus1.cursor_x);
  endtask

  task automatic test_replace;
    strobe(8'h75);
    n_cmp++; if (bus0.cursor_y !== 6'd28 || bus0.held_code !== 8'h75) begin n_err++; $display("FAIL up got y=%0d held=%h want 28/75", bus0.cursor_y, bus0.held_code); end
    strobe(8'h72);
    n_cmp++; if (bus0.cursor_y !== 6'd29 || bus0.held_code !== 8'h72) begin n_err++; $display("FAIL down_replace got y=%0d held=%h want 29/72", bus0.cursor_y, bus0.held_code); end
    n_cmp++; if (bus0.moved !== 1'b1) begin n_err++; $display("FAIL down_moved got %b want 1", bus0.moved); end
    strobe(8'h75);
    n_cmp++; if (bus0.cursor_y !== 6'd28 || bus0.held_code !== 8'h75) begin n_err++; $display("FAIL up_again got y=%0d held=%h want 28/75", bus0.cursor_y, bus0.held_code); end
    strobe(8'h75);
    n_cmp++; if (bus0.cursor_y !== 6'd28 || bus0.held_code !== 8'h00 || bus0.moved !== 1'b0) begin
      n_err++; $display("FAIL up_release got y=%0d held=%h moved=%b want 28/00/0", bus0.cursor_y, bus0.held_code, bus0.moved);
    end
    $display("test_replace: y=%0d held=%h", bus0.cursor_y, bus0.held_code);
  endtask

  task automatic test_back_to_back;
    drive(8'h5A, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus0.select !== 1'b1 || bus0.held_code !== 8'h5A) begin n_err++; $display("FAIL b2b_1 got sel=%b held=%h want 1/5a", bus0.select, bus0.held_code); end
    drive(8'h1C, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus0.select !== 1'b0 || bus0.held_code !== 8'h5A) begin n_err++; $display("FAIL b2b_2 got sel=%b held=%h want 0/5a", bus0.select, bus0.held_code); end
    drive(8'h5A, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0);
    n_cmp++; if (bus0.select !== 1'b0 || bus0.held_code !== 8'h00) begin n_err++; $display("FAIL b2b_3 got sel=%b held=%h want 0/00", bus0.select, bus0.held_code); end
    n_cmp++; if (bus0.cursor_x !== 7'd0 || bus0.cursor_y !== 6'd28 || bus0.moved !== 1'b0) begin
      n_err++; $display("FAIL b2b_cursor got x=%0d y=%0d moved=%b want 0/28/0", bus0.cursor_x, bus0.cursor_y, bus0.moved);
    end
    idle(1);
    n_cmp++; if (bus0.select !== 1'b0) begin n_err++; $display("FAIL b2b_4 got sel=%b want 0", bus0.select); end
    $display("test_back_to_back: sel=%b held=%h", bus0.select, bus0.held_code);
  endtask

  task automatic test_reset_mid_hold;
    strobe(8'h74);
    n_cmp++; if (bus0.cursor_x !== 7'd1 || bus0.held_code !== 8'h74) begin n_err++; $display("FAIL hold got x=%0d held=%h want 1/74", bus0.cursor_x, bus0.held_code); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus0.cursor_x !== 7'd39 || bus0.held_code !== 8'h00 || bus0.moved !== 1'b0) begin
      n_err++; $display("FAIL async_rst got x=%0d held=%h moved=%b want 39/00/0", bus0.cursor_x, bus0.held_code, bus0.moved);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    n_cmp++; if (bus0.cursor_x !== 7'd39 || bus0.cursor_y !== 6'd29) begin n_err++; $display("FAIL post_rst got x=%0d y=%0d want 39/29", bus0.cursor_x, bus0.cursor_y); end
    strobe(8'h74);
    n_cmp++; if (bus0.cursor_x !== 7'd40 || bus0.held_code !== 8'h74 || bus0.moved !== 1'b1) begin
      n_err++; $display("FAIL post_rst_press got x=%0d held=%h moved=%b want 40/74/1", bus0.cursor_x, bus0.held_code, bus0.moved);
    end
    $display("test_reset_mid_hold: x=%0d held=%h", bus0.cursor_x, bus0.held_code);
  endtask

  initial begin
    drive(8'h00, 1'b0);
    @(negedge clk);
    test_reset();
    test_tap_right();
    test_left_edge();
    test_replace();
    test_back_to_back();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
